// File: rtl/seg_reader_pkg.sv
// Shared types and segment patterns for the 7-segment bus reader.
// Segment bit order is gfedcba (bit0 = a, bit6 = g), 1 = lit.
package seg_reader_pkg;

    typedef enum logic [1:0] {
        KIND_BLANK = 2'd0,
        KIND_VALID = 2'd1,
        KIND_ERROR = 2'd2
    } seg_kind_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;

endpackage

// File: rtl/seg_pattern_decoder.sv
// Combinational 7-segment pattern to hex value decoder.
// Blank and unrecognised patterns report value 0.
module seg_pattern_decoder
    import seg_reader_pkg::*;
(
    input  logic [6:0] seg,
    output seg_kind_t  kind,
    output logic [3:0] value
);

    // Look up the lit-segment pattern; anything unlisted is an error
    always_comb begin
        kind  = KIND_VALID;
        value = 4'h0;
        case (seg)
            SEG_0:     value = 4'h0;
            SEG_1:     value = 4'h1;
            SEG_2:     value = 4'h2;
            SEG_3:     value = 4'h3;
            SEG_4:     value = 4'h4;
            SEG_5:     value = 4'h5;
            SEG_6:     value = 4'h6;
            SEG_7:     value = 4'h7;
            SEG_8:     value = 4'h8;
            SEG_9:     value = 4'h9;
            SEG_A:     value = 4'hA;
            SEG_B:     value = 4'hB;
            SEG_C:     value = 4'hC;
            SEG_D:     value = 4'hD;
            SEG_E:     value = 4'hE;
            SEG_F:     value = 4'hF;
            SEG_BLANK: kind  = KIND_BLANK;
            default:   kind  = KIND_ERROR;
        endcase
    end

endmodule

// File: rtl/seg_display_reader.sv
// Multiplexed 7-segment bus reader: synchronises the bus, waits for the
// digit select to settle, takes one sample per select period, commits a
// digit after STABLE_SCANS identical samples and reports each committed
// change on a valid/ready event port.
// Optional build macro SEG_ACTIVE_LOW_EN: inputs are active-low
// (common-anode), inverted right after the synchronisers.
module seg_display_reader
    import seg_reader_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int SETTLE_CYCLES = 3,
    parameter int STABLE_SCANS  = 2,
    localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_in,
    input  logic                    dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [IDX_W-1:0]        evt_digit,
    output logic [3:0]              evt_value,
    output logic                    evt_dp,
    output logic                    evt_blank,
    output logic                    evt_error,
    output logic [4*NUM_DIGITS-1:0] snapshot,
    output logic                    scan_err
);

    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int CNT_W = $clog2(STABLE_SCANS + 1);

`ifdef SEG_ACTIVE_LOW_EN
    localparam logic POL = 1'b1;
`else
    localparam logic POL = 1'b0;
`endif

    logic [6:0]            seg_p0, seg_p1, seg_s;
    logic                  dp_p0, dp_p1, dp_s;
    logic [NUM_DIGITS-1:0] sel_p0, sel_p1, sel_s;

    // Two-flop synchronisers; reset to the idle (unlit/inactive) raw level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_p0 <= {7{POL}};
            seg_p1 <= {7{POL}};
            dp_p0  <= POL;
            dp_p1  <= POL;
            sel_p0 <= {NUM_DIGITS{POL}};
            sel_p1 <= {NUM_DIGITS{POL}};
        end else begin
            seg_p0 <= seg_in;
            seg_p1 <= seg_p0;
            dp_p0  <= dp_in;
            dp_p1  <= dp_p0;
            sel_p0 <= digit_sel;
            sel_p1 <= sel_p0;
        end
    end

    assign seg_s = seg_p1 ^ {7{POL}};
    assign dp_s  = dp_p1 ^ POL;
    assign sel_s = sel_p1 ^ {NUM_DIGITS{POL}};

    // ---- settle: one sample per select period ----
    logic [NUM_DIGITS-1:0] sel_prev;
    logic [SET_W-1:0]      settle_cnt;
    logic                  sel_changed, fire, onehot, sample, bad_sel;

    assign sel_changed = (sel_s != sel_prev);
    assign fire        = !sel_changed && (settle_cnt == SET_W'(1));
    assign onehot      = (sel_s != '0) && ((sel_s & (sel_s - 1'b1)) == '0);
    assign sample      = fire && onehot;
    assign bad_sel     = fire && (sel_s != '0) && !onehot;

    // Reload the settle counter on every select change, count down otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_prev   <= '0;
            settle_cnt <= '0;
        end else begin
            sel_prev <= sel_s;
            if (sel_changed)
                settle_cnt <= SET_W'(SETTLE_CYCLES);
            else if (settle_cnt != '0)
                settle_cnt <= settle_cnt - SET_W'(1);
        end
    end

    logic [IDX_W-1:0] sel_idx;

    // Index of the active digit (only meaningful when one-hot)
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (sel_s[i]) sel_idx = IDX_W'(i);
    end

    seg_kind_t  samp_kind;
    logic [3:0] samp_val;

    seg_pattern_decoder u_dec (
        .seg   (seg_s),
        .kind  (samp_kind),
        .value (samp_val)
    );

    // ---- stability filter and committed state ----
    seg_kind_t        cand_kind [NUM_DIGITS];
    logic [3:0]       cand_val  [NUM_DIGITS];
    logic             cand_dp   [NUM_DIGITS];
    logic [CNT_W-1:0] cnt       [NUM_DIGITS];
    seg_kind_t        com_kind  [NUM_DIGITS];
    logic [3:0]       com_val   [NUM_DIGITS];
    logic             com_dp    [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] dirty;

    logic             match, commit;
    logic [CNT_W-1:0] cnt_n;

    assign match  = (samp_kind == cand_kind[sel_idx]) &&
                    (samp_val == cand_val[sel_idx]) && (dp_s == cand_dp[sel_idx]);
    assign cnt_n  = !match ? CNT_W'(1) :
                    (cnt[sel_idx] == CNT_W'(STABLE_SCANS)) ? cnt[sel_idx] :
                    cnt[sel_idx] + CNT_W'(1);
    assign commit = sample && (cnt_n == CNT_W'(STABLE_SCANS)) &&
                    ((samp_kind != com_kind[sel_idx]) ||
                     (samp_val != com_val[sel_idx]) || (dp_s != com_dp[sel_idx]));

    // ---- event arbitration: lowest-index dirty digit first ----
    logic                  load, pick_any;
    logic [IDX_W-1:0]      pick_idx;
    logic [NUM_DIGITS-1:0] dirty_clr, dirty_set;

    assign load = !evt_valid || evt_ready;

    // Priority pick of the lowest dirty digit and dirty update masks
    always_comb begin
        pick_any = |dirty;
        pick_idx = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--)
            if (dirty[i]) pick_idx = IDX_W'(i);
        dirty_clr = (load && pick_any) ? (NUM_DIGITS'(1) << pick_idx) : '0;
        dirty_set = commit ? (NUM_DIGITS'(1) << sel_idx) : '0;
    end

    // Candidate/commit update on each sample; dirty set wins over clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                cand_kind[i] <= KIND_BLANK;
                cand_val[i]  <= 4'h0;
                cand_dp[i]   <= 1'b0;
                cnt[i]       <= '0;
                com_kind[i]  <= KIND_BLANK;
                com_val[i]   <= 4'h0;
                com_dp[i]    <= 1'b0;
            end
            dirty    <= '0;
            scan_err <= 1'b0;
        end else begin
            if (sample) begin
                cand_kind[sel_idx] <= samp_kind;
                cand_val[sel_idx]  <= samp_val;
                cand_dp[sel_idx]   <= dp_s;
                cnt[sel_idx]       <= cnt_n;
                if (commit) begin
                    com_kind[sel_idx] <= samp_kind;
                    com_val[sel_idx]  <= samp_val;
                    com_dp[sel_idx]   <= dp_s;
                end
            end
            dirty <= (dirty & ~dirty_clr) | dirty_set;
            if (bad_sel) scan_err <= 1'b1;
        end
    end

    // Output event register; payload holds while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_valid <= 1'b0;
            evt_digit <= '0;
            evt_value <= 4'h0;
            evt_dp    <= 1'b0;
            evt_blank <= 1'b0;
            evt_error <= 1'b0;
        end else if (load) begin
            evt_valid <= pick_any;
            if (pick_any) begin
                evt_digit <= pick_idx;
                evt_value <= com_val[pick_idx];
                evt_dp    <= com_dp[pick_idx];
                evt_blank <= (com_kind[pick_idx] == KIND_BLANK);
                evt_error <= (com_kind[pick_idx] == KIND_ERROR);
            end
        end
    end

    // Committed values packed four bits per digit
    always_comb begin
        snapshot = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            snapshot[4*i +: 4] = com_val[i];
    end

endmodule

// File: tb/tb_seg_display_reader.sv
// Directed bench for seg_display_reader (4 digits, settle 3, stable 2).
// Stimulus is given in active-high terms and inverted when the design is
// built with SEG_ACTIVE_LOW_EN.
module tb_seg_display_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg_in;
    logic        dp_in;
    logic [3:0]  digit_sel;
    logic        evt_valid;
    logic        evt_ready;
    logic [1:0]  evt_digit;
    logic [3:0]  evt_value;
    logic        evt_dp;
    logic        evt_blank;
    logic        evt_error;
    logic [15:0] snapshot;
    logic        scan_err;

    seg_display_reader #(
        .NUM_DIGITS    (4),
        .SETTLE_CYCLES (3),
        .STABLE_SCANS  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_in    (seg_in),
        .dp_in     (dp_in),
        .digit_sel (digit_sel),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_digit (evt_digit),
        .evt_value (evt_value),
        .evt_dp    (evt_dp),
        .evt_blank (evt_blank),
        .evt_error (evt_error),
        .snapshot  (snapshot),
        .scan_err  (scan_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] digit;
        logic [3:0] value;
        logic       dp;
        logic       blank;
        logic       error;
    } evt_t;

    typedef struct {
        int         digit;
        logic [6:0] seg;
        logic       dp;
        logic [3:0] value;
        logic       blank;
        logic       error;
    } vec_t;

    evt_t evq[$];
    vec_t tbl[18];
    int   checks = 0;
    int   errors = 0;

    // Record every accepted event (handshake completes at the next rising edge)
    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready)
            evq.push_back('{evt_digit, evt_value, evt_dp, evt_blank, evt_error});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [3:0] sel, input logic [6:0] seg, input logic dp);
`ifdef SEG_ACTIVE_LOW_EN
        digit_sel = ~sel;
        seg_in    = ~seg;
        dp_in     = ~dp;
`else
        digit_sel = sel;
        seg_in    = seg;
        dp_in     = dp;
`endif
    endtask

    // One select period on digit d, followed by a short idle gap
    task automatic scan(input int d, input logic [6:0] seg, input logic dp);
        drive(4'(1 << d), seg, dp);
        step(8);
        drive(4'b0000, 7'h00, 1'b0);
        step(2);
    endtask

    task automatic expect_evt(input string name, input int d, input logic [3:0] v,
                              input logic dp, input logic bl, input logic er);
        evt_t e;
        int   waited;
        waited = 0;
        while (evq.size() == 0 && waited < 100) begin
            step(1);
            waited++;
        end
        if (evq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: no event within 100 cycles, required digit %0d value %0h", name, d, v);
        end else begin
            e = evq.pop_front();
            chk({name, ".digit"}, 32'(e.digit), 32'(d));
            chk({name, ".value"}, 32'(e.value), 32'(v));
            chk({name, ".dp"},    32'(e.dp),    32'(dp));
            chk({name, ".blank"}, 32'(e.blank), 32'(bl));
            chk({name, ".error"}, 32'(e.error), 32'(er));
        end
    endtask

    task automatic expect_none(input string name);
        step(20);
        chk(name, 32'(evq.size()), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{2, 7'h49, 1'b0, 4'h0, 1'b0, 1'b1};
        tbl[1]  = '{2, 7'h00, 1'b0, 4'h0, 1'b1, 1'b0};
        tbl[2]  = '{0, 7'h3F, 1'b1, 4'h0, 1'b0, 1'b0};
        tbl[3]  = '{1, 7'h06, 1'b0, 4'h1, 1'b0, 1'b0};
        tbl[4]  = '{2, 7'h5B, 1'b0, 4'h2, 1'b0, 1'b0};
        tbl[5]  = '{3, 7'h4F, 1'b0, 4'h3, 1'b0, 1'b0};
        tbl[6]  = '{0, 7'h66, 1'b0, 4'h4, 1'b0, 1'b0};
        tbl[7]  = '{1, 7'h6D, 1'b0, 4'h5, 1'b0, 1'b0};
        tbl[8]  = '{2, 7'h7D, 1'b0, 4'h6, 1'b0, 1'b0};
        tbl[9]  = '{3, 7'h07, 1'b0, 4'h7, 1'b0, 1'b0};
        tbl[10] = '{0, 7'h7F, 1'b0, 4'h8, 1'b0, 1'b0};
        tbl[11] = '{1, 7'h6F, 1'b0, 4'h9, 1'b0, 1'b0};
        tbl[12] = '{2, 7'h77, 1'b0, 4'hA, 1'b0, 1'b0};
        tbl[13] = '{3, 7'h7C, 1'b0, 4'hB, 1'b0, 1'b0};
        tbl[14] = '{0, 7'h39, 1'b0, 4'hC, 1'b0, 1'b0};
        tbl[15] = '{1, 7'h5E, 1'b0, 4'hD, 1'b0, 1'b0};
        tbl[16] = '{2, 7'h79, 1'b0, 4'hE, 1'b0, 1'b0};
        tbl[17] = '{3, 7'h71, 1'b1, 4'hF, 1'b0, 1'b0};

        rst       = 1'b1;
        evt_ready = 1'b0;
        drive(4'b0000, 7'h00, 1'b0);
        step(3);
        chk("reset.evt_valid", 32'(evt_valid), 32'd0);
        chk("reset.payload",   32'({evt_digit, evt_value, evt_dp, evt_blank, evt_error}), 32'd0);
        chk("reset.snapshot",  32'(snapshot), 32'd0);
        chk("reset.scan_err",  32'(scan_err), 32'd0);
        rst = 1'b0;
        step(3);

        // Two identical periods on digit 0 commit value 2
        evt_ready = 1'b1;
        scan(0, 7'h5B, 1'b0);
        scan(0, 7'h5B, 1'b0);
        expect_evt("t1", 0, 4'h2, 1'b0, 1'b0, 1'b0);
        chk("t1.snapshot", 32'(snapshot[3:0]), 32'h2);
        expect_none("t1.single_event");

        // A one-period glitch breaks the stability run on digit 1
        scan(1, 7'h5B, 1'b0);
        scan(1, 7'h06, 1'b0);
        scan(1, 7'h5B, 1'b0);
        expect_none("t2.no_event");
        chk("t2.snapshot", 32'(snapshot[7:4]), 32'h0);

        // Two selects at once: no sample, sticky scan error
        drive(4'b0110, 7'h3F, 1'b0);
        step(6);
        drive(4'b0000, 7'h00, 1'b0);
        step(4);
        chk("t3.scan_err", 32'(scan_err), 32'd1);
        expect_none("t3.no_event");
        chk("t3.scan_err_sticky", 32'(scan_err), 32'd1);

        // Back-pressure: four commits queue up behind a stalled event
        evt_ready = 1'b0;
        for (int r = 0; r < 2; r++) begin
            scan(0, 7'h4F, 1'b0);
            scan(1, 7'h66, 1'b0);
            scan(2, 7'h6D, 1'b0);
            scan(3, 7'h7D, 1'b0);
            if (r == 0) chk("t4.no_valid_yet", 32'(evt_valid), 32'd0);
        end
        chk("t4.valid_held", 32'(evt_valid), 32'd1);
        chk("t4.stall_payload", 32'({evt_digit, evt_value}), 32'({2'd0, 4'h3}));
        step(5);
        chk("t4.stall_stable", 32'({evt_valid, evt_digit, evt_value}), 32'({1'b1, 2'd0, 4'h3}));
        chk("t4.snapshot", 32'(snapshot), 32'h6543);
        evt_ready = 1'b1;
        expect_evt("t4.e0", 0, 4'h3, 1'b0, 1'b0, 1'b0);
        expect_evt("t4.e1", 1, 4'h4, 1'b0, 1'b0, 1'b0);
        expect_evt("t4.e2", 2, 4'h5, 1'b0, 1'b0, 1'b0);
        expect_evt("t4.e3", 3, 4'h6, 1'b0, 1'b0, 1'b0);
        expect_none("t4.no_extra");

        // Table: error, blank and every hex glyph across the digits
        for (int i = 0; i < 18; i++) begin
            scan(tbl[i].digit, tbl[i].seg, tbl[i].dp);
            scan(tbl[i].digit, tbl[i].seg, tbl[i].dp);
            expect_evt($sformatf("tbl%0d", i), tbl[i].digit, tbl[i].value,
                       tbl[i].dp, tbl[i].blank, tbl[i].error);
            chk($sformatf("tbl%0d.snapshot", i),
                32'((snapshot >> (4 * tbl[i].digit)) & 16'hF), 32'(tbl[i].value));
        end
        chk("tbl.final_snapshot", 32'(snapshot), 32'hFEDC);

        // Reset while an event is pending drops it
        evt_ready = 1'b0;
        scan(1, 7'h3F, 1'b0);
        scan(1, 7'h3F, 1'b0);
        chk("t6.pending", 32'(evt_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6.reset_valid",    32'(evt_valid), 32'd0);
        chk("t6.reset_snapshot", 32'(snapshot), 32'd0);
        chk("t6.reset_scan_err", 32'(scan_err), 32'd0);
        step(2);
        rst = 1'b0;
        step(3);
        evt_ready = 1'b1;
        scan(0, 7'h3F, 1'b0);
        scan(0, 7'h3F, 1'b0);
        expect_evt("t6.fresh", 0, 4'h0, 1'b0, 1'b0, 1'b0);
        expect_none("t6.no_stale");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
